// File: rtl/dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_queue
// Description : In-order FIFO between decode and one reservation station.
//               Absorbs decoded words while the station stalls, presents the
//               oldest one per cycle, back-pressures decode when full, and
//               supports a synchronous flush. Outputs come from flops only.
// Revision    : 1.0 - initial release
// ============================================================================
module dispatch_queue #(
    parameter int queueWidth       = 302,
    parameter int depth            = 8,
    parameter int depthBits        = 3,
    parameter int RStationInstance = 0
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    input  logic                  enable_i,
    input  logic [queueWidth-1:0] instruction_i,
    output logic                  stall_o,
    output logic                  enable_o,
    output logic [queueWidth-1:0] instruction_o,
    input  logic                  stall_i,
    output logic [depthBits:0]    count_o,
    output logic                  overflow_o
);

    localparam logic [depthBits:0] c_depth = (depthBits + 1)'(depth);

    logic [queueWidth-1:0] mem_q [depth];
    logic [queueWidth-1:0] mem_d [depth];
    logic [depthBits-1:0]  head_q, head_d;
    logic [depthBits-1:0]  tail_q, tail_d;
    logic [depthBits:0]    count_q, count_d;
    logic                  overflow_q, overflow_d;

    logic w_full;
    logic w_not_empty;
    logic w_push;
    logic w_pop;

    // Marker block that only elaborates for an inconsistent parameter set
    // (depth not 2**depthBits, depth below 2, or station index out of 0-7).
    if ((1 << depthBits) != depth || depth < 2 ||
        RStationInstance < 0 || RStationInstance > 7) begin : g_bad_params
    end

    // Handshake decode uses registered occupancy only, so a push offered
    // while full is dropped even if a pop frees a slot in the same cycle.
    assign w_full      = (count_q == c_depth);
    assign w_not_empty = (count_q != '0);
    assign w_push      = enable_i && !w_full;
    assign w_pop       = w_not_empty && !stall_i;

    // Next-state for pointers, occupancy and the sticky overflow flag;
    // flush wins over push and pop but leaves overflow untouched.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (w_push) begin
                tail_d = tail_q + 1'b1;
            end
            if (w_pop) begin
                head_d = head_q + 1'b1;
            end
            if (w_push && !w_pop) begin
                count_d = count_q + 1'b1;
            end else if (!w_push && w_pop) begin
                count_d = count_q - 1'b1;
            end
            if (enable_i && w_full) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Storage write: the accepted word lands in the slot under the tail.
    always_comb begin
        mem_d = mem_q;
        if (!flush_i && w_push) begin
            mem_d[tail_q] = instruction_i;
        end
    end

    // Storage array carries no reset; stale words are masked by count.
    always_ff @(posedge clock_i) begin
        mem_q <= mem_d;
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign enable_o      = w_not_empty;
    assign stall_o       = w_full;
    assign count_o       = count_q;
    assign overflow_o    = overflow_q;
    assign instruction_o = w_not_empty ? mem_q[head_q] : '0;

endmodule
`default_nettype wire

// File: tb/tb_dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_dispatch_queue
// Description : Self-checking bench for dispatch_queue: directed scenarios
//               followed by random traffic, compared against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dispatch_queue;

    localparam int W = 302;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         en = 1'b0;
    logic         stall_in = 1'b0;
    logic [W-1:0] din = '0;
    logic         stall_out;
    logic         en_out;
    logic [W-1:0] dout;
    logic [3:0]   count;
    logic         ovf_out;

    dispatch_queue #(
        .queueWidth      (W),
        .depth           (D),
        .depthBits       (3),
        .RStationInstance(0)
    ) dut (
        .clock_i      (clk),
        .reset_i      (rst),
        .flush_i      (flush),
        .enable_i     (en),
        .instruction_i(din),
        .stall_o      (stall_out),
        .enable_o     (en_out),
        .instruction_o(dout),
        .stall_i      (stall_in),
        .count_o      (count),
        .overflow_o   (ovf_out)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue of words plus the sticky overflow bit.
    logic [W-1:0] model [$];
    bit           ovf = 1'b0;
    int           n_pass = 0;
    int           n_fail = 0;
    int           n_checks = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [W-1:0] exp_word;
        exp_word = (model.size() != 0) ? model[0] : '0;
        chk({tag, ".count"}, W'(count), W'(model.size()));
        chk({tag, ".enable"}, W'(en_out), W'(model.size() != 0));
        chk({tag, ".stall"}, W'(stall_out), W'(model.size() == D));
        chk({tag, ".word"}, dout, exp_word);
        chk({tag, ".ovf"}, W'(ovf_out), W'(ovf));
    endtask

    // One clock: evaluate the rules on pre-edge state, then check after it.
    task automatic step(input string tag);
        bit           full;
        bit           push;
        bit           pop;
        bit           f;
        bit           e;
        logic [W-1:0] d;
        full = (model.size() == D);
        push = en && !full;
        pop  = (model.size() != 0) && !stall_in;
        f    = flush;
        e    = en;
        d    = din;
        @(posedge clk);
        if (f) begin
            model.delete();
        end else begin
            if (e && full) ovf = 1'b1;
            if (pop) void'(model.pop_front());
            if (push) model.push_back(d);
        end
        #1;
        check_all(tag);
    endtask

    task automatic mid_reset(input string tag);
        #3 rst = 1'b1;
        model.delete();
        ovf = 1'b0;
        #1 check_all(tag);
        #2 rst = 1'b0;
    endtask

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < 10; i++) r = (r << 32) | W'($urandom());
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Reset asserted between edges with three words queued
        stall_in = 1'b1;
        en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            din = W'(i);
            step("push3");
        end
        en = 1'b0;
        mid_reset("rst_mid");

        // Fill to full while the station stalls
        stall_in = 1'b1;
        en = 1'b1;
        for (int i = 1; i <= D; i++) begin
            din = W'(i);
            step("fill");
        end
        chk("fill.stall_hi", W'(stall_out), W'(1));

        // Overflow: 0x99 offered while full is dropped
        din = W'('h99);
        step("ovf");
        en = 1'b0;
        chk("ovf.flag", W'(ovf_out), W'(1));
        chk("ovf.count", W'(count), W'(8));

        // Drain in order; stall drops after the first pop
        stall_in = 1'b0;
        for (int i = 1; i <= D; i++) begin
            chk("drain.order", dout, W'(i));
            step("drain");
            if (i == 1) chk("drain.stall_lo", W'(stall_out), W'(0));
        end

        // Flush does not clear overflow
        flush = 1'b1;
        step("flush_ovf");
        flush = 1'b0;
        chk("flush.ovf_kept", W'(ovf_out), W'(1));

        // Streaming at occupancy 2 long enough to wrap pointers
        stall_in = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            din = rnd_word();
            step("stream_pre");
        end
        stall_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            din = rnd_word();
            step("stream");
            chk("stream.count2", W'(count), W'(2));
        end
        en = 1'b0;
        step("stream_drain");
        step("stream_drain");

        // Empty-queue push becomes visible one cycle later
        chk("bypass.pre_en", W'(en_out), W'(0));
        en = 1'b1;
        din = W'('hABC);
        step("bypass_push");
        en = 1'b0;
        chk("bypass.word", dout, W'('hABC));
        step("bypass_pop");
        chk("bypass.empty", W'(en_out), W'(0));

        // Flush beats a simultaneous push and pop
        stall_in = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din = rnd_word();
            step("fp_fill");
        end
        flush = 1'b1;
        din = W'('h77);
        stall_in = 1'b0;
        step("fp_flush");
        flush = 1'b0;
        chk("fp.count0", W'(count), W'(0));
        din = W'('h11);
        step("fp_push");
        en = 1'b0;
        chk("fp.next_word", dout, W'('h11));
        step("fp_pop");

        // Random traffic from a clean reset
        mid_reset("rst_rand");
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(0, 99) < 60);
            stall_in = ($urandom_range(0, 99) < 40);
            flush    = ($urandom_range(0, 99) < 3);
            din      = rnd_word();
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dispatch_queue.md
# dispatch_queue

In-order FIFO between the decode stage and a reservation station. It absorbs decoded instruction words while the reservation station is stalled and presents them one per cycle, oldest first. It back-pressures decode with a full indication and supports a pipeline flush. There is one instance per reservation station, selected by `RStationInstance`.

## Interface
- `queueWidth`, 302, width of one decoded instruction word.
- `depth`, 8, number of entries; power of two, at least 2.
- `depthBits`, 3, log2(`depth`).
- `RStationInstance`, 0, index of the reservation station being fed (0-7).

- `clock_i`  in  1  single clock; all state changes on its rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `flush_i`  in  1  synchronous flush; discards all queued entries.
- `enable_i`  in  1  decode presents a valid instruction on `instruction_i` this cycle.
- `instruction_i`  in  `queueWidth`  decoded instruction word.
- `stall_o`  out  1  queue full; decode must not assert `enable_i`.
- `enable_o`  out  1  `instruction_o` holds a valid entry for the reservation station.
- `instruction_o`  out  `queueWidth`  oldest queued instruction word.
- `stall_i`  in  1  reservation station cannot accept this cycle.
- `count_o`  out  `depthBits`+1  number of occupied entries, 0 to `depth`.
- `overflow_o`  out  1  sticky error flag: `enable_i` arrived while full.

## Operation
- State:
  - storage array of `depth` x `queueWidth`;
  - head pointer and tail pointer, each `depthBits` wide;
  - occupancy count, `depthBits`+1 wide;
  - overflow flag.
- Pointers wrap modulo `depth`: index `depth`-1 plus 1 gives 0. No other wrap handling.
- Outputs are decoded from registered state only. No combinational path from any input to any output.
  - `enable_o` = (count != 0).
  - `stall_o` = (count == `depth`).
  - `count_o` = count.
  - `instruction_o` = storage[head] when count != 0; all zeros when count == 0.
- Push = `enable_i` && !`stall_o`. A push writes `instruction_i` to storage[tail] and increments tail.
- Pop = `enable_o` && !`stall_i`. A pop increments head.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - unchanged when push and pop happen together, or when neither happens.
- Full with `enable_i` high:
  - The push is rejected and the word is dropped.
  - `overflow_o` is set and stays set until reset. Flush does not clear it.
  - A pop in the same cycle still happens. Because `stall_o` is registered, the word is still dropped.
- Empty with `enable_i` high:
  - No pop is possible because `enable_o` is low.
  - The word becomes visible on `instruction_o` the next cycle.
- Flush has priority over push and pop.
  - `flush_i` high: head, tail and count go to 0, and `instruction_i` is ignored that cycle.
  - Storage contents are not cleared.
  - `overflow_o` is unchanged.
- Reset, asynchronous and effective immediately, including mid-operation:
  - head, tail, count and overflow go to 0.
  - Outputs therefore read `enable_o`=0, `stall_o`=0, `count_o`=0, `instruction_o`=0, `overflow_o`=0.
  - Storage is not reset.
- Debug builds only:
  - On reset, open the log file `DispatchQueue<RStationInstance>.log`.
  - Log every push, pop, flush and overflow with `count_o`.
  - Mirror the same lines to the console under `DEBUG`.

## Timing
- Latency from push to presentation: 1 cycle. A word pushed at edge N is on `instruction_o`, with `enable_o`=1, after edge N when the queue was empty.
- Throughput: one push and one pop per cycle, sustained, with the queue neither empty nor full.
- `stall_o` rises the cycle after the push that fills the queue. It falls the cycle after the first pop from full.
- The reservation station samples `instruction_o` at the edge where `enable_o` && !`stall_i`. The next entry appears after that edge.
- Reset assertion acts asynchronously. Reset deassertion is synchronous to `clock_i` and is the integrator's responsibility.

## Test plan
- **Reset mid-operation:** push 3 words, then assert `reset_i` between edges → immediately `enable_o`=0, `count_o`=0, `instruction_o`=0, `overflow_o`=0.
- **Fill to full:** with `stall_i`=1, push words 0x1..0x8 on 8 consecutive cycles → `stall_o`=1 and `count_o`=8. Then release `stall_i` → pops return 0x1..0x8 in order over 8 cycles; `stall_o` drops after the first pop.
- **Overflow:** with the queue full and `stall_i`=1, assert `enable_i` with 0x99 → `count_o` stays 8, `overflow_o`=1, and 0x99 never appears on `instruction_o`. `overflow_o` stays 1 after a subsequent flush.
- **Streaming:** `count_o`=2, `stall_i`=0, push every cycle for 20 cycles → `count_o` stays 2 and output order equals input order. Run long enough that head and tail wrap at least twice.
- **Empty bypass timing:** on an empty queue push 0xABC with `stall_i`=0 → `enable_o`=0 in the push cycle, `enable_o`=1 with 0xABC the next cycle, and back to empty after the pop.
- **Flush priority:** `count_o`=5, then in one cycle assert `flush_i`, `enable_i` (with 0x77) and a pop → next cycle `count_o`=0 and `enable_o`=0. A later push of 0x11 is the next word output.
